exe_unit_w2: RTL

Second-generation parametrised execution unit. It adds three things over a purely single-cycle opcode-select unit: a valid/ready input handshake, an output valid strobe, and an iterative multi-cycle unsigned multiplier alongside the single-cycle ALU operations. It sits between the operand/opcode source and the result consumer, registering the result and a 4-bit status word. Result and status are held stable until the next operation completes.

---
 rtl/exe_unit_w2_if.sv | 27 ++
 rtl/exe_unit_w2.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/exe_unit_w2_if.sv
// Operand/opcode request and result/status bus of the execution unit.
interface exe_unit_w2_if #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 3
);
    logic         i_valid;
    logic         o_ready;
    logic [n-1:0] i_oper;
    logic [m-1:0] i_argA;
    logic [m-1:0] i_argB;
    logic         o_valid;
    logic [m-1:0] o_result;
    logic [3:0]   o_status;
    logic         o_err;

    // Operand source / result consumer side
    modport master (
        output i_valid, i_oper, i_argA, i_argB,
        input  o_ready, o_valid, o_result, o_status, o_err
    );

    // Execution unit side
    modport slave (
        input  i_valid, i_oper, i_argA, i_argB,
        output o_ready, o_valid, o_result, o_status, o_err
    );
endinterface

// File: rtl/exe_unit_w2.sv
// Execution unit: single-cycle ALU ops plus an iterative shift-add unsigned multiplier.
module exe_unit_w2 #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 3
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    exe_unit_w2_if.slave bus
);
    localparam int unsigned PW = 2 * m;
    localparam int unsigned CW = $clog2(m);

    localparam logic [n-1:0] OP_ADD = n'(0);
    localparam logic [n-1:0] OP_SUB = n'(1);
    localparam logic [n-1:0] OP_AND = n'(2);
    localparam logic [n-1:0] OP_OR  = n'(3);
    localparam logic [n-1:0] OP_XOR = n'(4);
    localparam logic [n-1:0] OP_SHL = n'(5);
    localparam logic [n-1:0] OP_MUL = n'(6);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t         state_q, state_d;
    logic           ready_q;
    logic           valid_q, valid_d;
    logic [m-1:0]   result_q, result_d;
    logic [3:0]     status_q, status_d;
    logic           err_q, err_d;
    logic [PW-1:0]  mcand_q, mcand_d;
    logic [m-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           accept_c;
    logic           last_c;
    logic [m-1:0]   alu_res;
    logic [3:0]     alu_st;
    logic           alu_err;
    logic [PW-1:0]  acc_step;

    assign accept_c = bus.i_valid && ready_q;
    assign last_c   = (cnt_q == CW'(m - 1));
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : PW'(0));

    // Single-cycle ALU result and flags for the presented opcode
    always_comb begin
        logic [m:0] wide;
        logic       c;
        logic       v;
        wide    = '0;
        c       = 1'b0;
        v       = 1'b0;
        alu_res = '0;
        alu_err = 1'b0;
        case (bus.i_oper)
            OP_ADD: begin
                wide    = {1'b0, bus.i_argA} + {1'b0, bus.i_argB};
                alu_res = wide[m-1:0];
                c       = wide[m];
                v       = (bus.i_argA[m-1] == bus.i_argB[m-1]) && (alu_res[m-1] != bus.i_argA[m-1]);
            end
            OP_SUB: begin
                wide    = {1'b0, bus.i_argA} - {1'b0, bus.i_argB};
                alu_res = wide[m-1:0];
                c       = wide[m];
                v       = (bus.i_argA[m-1] != bus.i_argB[m-1]) && (alu_res[m-1] != bus.i_argA[m-1]);
            end
            OP_AND: alu_res = bus.i_argA & bus.i_argB;
            OP_OR:  alu_res = bus.i_argA | bus.i_argB;
            OP_XOR: alu_res = bus.i_argA ^ bus.i_argB;
            OP_SHL: begin
                alu_res = {bus.i_argA[m-2:0], 1'b0};
                c       = bus.i_argA[m-1];
                v       = bus.i_argA[m-1] ^ bus.i_argA[m-2];
            end
            OP_MUL: ;
            default: alu_err = 1'b1;
        endcase
        alu_st = alu_err ? 4'b0000 : {v, c, alu_res[m-1], (alu_res == '0)};
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
        end
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c && (bus.i_oper == OP_MUL)) state_d = S_MUL;
            S_MUL:   if (last_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: result capture and multiplier iteration
    always_comb begin
        valid_d  = 1'b0;
        result_d = result_q;
        status_d = status_q;
        err_d    = err_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (bus.i_oper == OP_MUL) begin
                        mcand_d  = {{m{1'b0}}, bus.i_argA};
                        mplier_d = bus.i_argB;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_res;
                        status_d = alu_st;
                        err_d    = alu_err;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_c) begin
                    valid_d  = 1'b1;
                    result_d = acc_step[m-1:0];
                    status_d = {(|acc_step[PW-1:m]), 1'b0, acc_step[m-1], (acc_step[m-1:0] == '0)};
                    err_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            status_q <= status_d;
            err_q    <= err_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_status = status_q;
    assign bus.o_err    = err_q;
endmodule
